// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one RV32I sized load/store at a time over
// a valid/ready handshake, answered after a fixed LATENCY from a word RAM.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       func3_q, func3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      ram_q [DEPTH_WORDS];
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      old_word_s;
    logic [31:0]      wr_word_s;
    logic             err_s;
    logic             ram_we_s;

    // Illegal funct3 (loads 011/110/111, stores 1xx), misalignment, or out of range.
    function automatic logic acc_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic bad_f3;
        logic mis;
        logic oor;
        case (f3)
            3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
            3'b100, 3'b101:         bad_f3 = we;
            default:                bad_f3 = 1'b1;
        endcase
        case (f3[1:0])
            2'b01:   mis = addr[0];
            2'b10:   mis = (addr[1:0] != 2'b00);
            default: mis = 1'b0;
        endcase
        oor = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        return bad_f3 | mis | oor;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return w;
            3'b100:  return {24'h000000, b};
            3'b101:  return {16'h0000, h};
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] res;
        res = old;
        case (f3)
            3'b000: begin
                case (lane)
                    2'd0:    res[7:0]   = wd[7:0];
                    2'd1:    res[15:8]  = wd[7:0];
                    2'd2:    res[23:16] = wd[7:0];
                    default: res[31:24] = wd[7:0];
                endcase
            end
            3'b001: begin
                if (lane[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            3'b010:  res = wd;
            default: res = old;
        endcase
        return res;
    endfunction

    assign idx_s      = addr_q[IDX_W+1:2];
    assign old_word_s = ram_q[idx_s];

    // Next-state, request latch and response capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        func3_d   = func3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ram_we_s  = 1'b0;
        err_s     = acc_err(we_q, func3_q, addr_q);
        wr_word_s = store_merge(func3_q, addr_q[1:0], old_word_s, wdata_q);
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    // Read uses the pre-write word, so a store never sees its own data.
                    state_d  = ST_RESP;
                    err_d    = err_s;
                    ram_we_s = we_q & ~err_s;
                    if (err_s || we_q) begin
                        rdata_d = 32'h0000_0000;
                    end else begin
                        rdata_d = load_extract(func3_q, addr_q[1:0], old_word_s);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            we_q    <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM array: no reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[idx_s] <= wr_word_s;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: dut0 (LATENCY 2, 256 words) and
// dut1 (LATENCY 1, 16 words) driven with directed requests.
module tb_dmem_responder;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_valid_s [2];
    logic        req_ready_s [2];
    logic        req_we_s    [2];
    logic [2:0]  req_func3_s [2];
    logic [31:0] req_addr_s  [2];
    logic [31:0] req_wdata_s [2];
    logic        rsp_valid_s [2];
    logic [31:0] rsp_rdata_s [2];
    logic        rsp_err_s   [2];

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_we(req_we_s[0]),
        .req_func3(req_func3_s[0]), .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]),
        .rsp_valid(rsp_valid_s[0]), .rsp_rdata(rsp_rdata_s[0]), .rsp_err(rsp_err_s[0])
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_we(req_we_s[1]),
        .req_func3(req_func3_s[1]), .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]),
        .rsp_valid(rsp_valid_s[1]), .rsp_rdata(rsp_rdata_s[1]), .rsp_err(rsp_err_s[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_acc [2];
    bit   prev_hold [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input int d);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        n_checks++;
        if (sz == 0) begin
            n_fail++;
            $display("FAIL unexpected_rsp dut%0d cyc %0d: got rdata=%h err=%b, required no response",
                     d, cyc, rsp_rdata_s[d], rsp_err_s[d]);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (rsp_rdata_s[d] !== e.rdata || rsp_err_s[d] !== e.err || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL rsp dut%0d: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                         d, rsp_rdata_s[d], rsp_err_s[d], cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask

    // Monitor: compare every response pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid_s[d] === 1'b1) check_rsp(d);
            end
        end
    end

    // Issue one request at a negedge; with hold, valid stays high and junk
    // stores to the same address are driven while the responder is busy.
    task automatic send(input int d, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                        input bit hold);
        int   guard;
        int   c;
        int   low;
        exp_t e;
        guard = 0;
        while (req_ready_s[d] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);
        req_we_s[d]    = we;
        req_func3_s[d] = f3;
        req_addr_s[d]  = addr;
        req_wdata_s[d] = wdata;
        req_valid_s[d] = 1'b1;
        c = cyc;
        if (prev_hold[d]) check($sformatf("accept_interval_dut%0d", d), c + 1 - last_acc[d], lat_of(d) + 2);
        @(posedge clk);
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = c + 1 + lat_of(d);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        last_acc[d]  = c + 1;
        prev_hold[d] = hold;
        @(negedge clk);
        low = 0;
        while (req_ready_s[d] !== 1'b1 && low < 50) begin
            low++;
            if (hold) begin
                req_we_s[d]    = 1'b1;
                req_func3_s[d] = F_W;
                req_addr_s[d]  = addr;
                req_wdata_s[d] = $urandom;
            end else begin
                req_valid_s[d] = 1'b0;
            end
            @(negedge clk);
        end
        check($sformatf("ready_low_cycles_dut%0d", d), low, lat_of(d) + 1);
        if (!hold) req_valid_s[d] = 1'b0;
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check($sformatf("%s_ready_dut%0d", tag, d), {31'd0, req_ready_s[d]}, 32'd1);
        check($sformatf("%s_valid_dut%0d", tag, d), {31'd0, rsp_valid_s[d]}, 32'd0);
        check($sformatf("%s_rdata_dut%0d", tag, d), rsp_rdata_s[d], 32'h0);
        check($sformatf("%s_err_dut%0d", tag, d), {31'd0, rsp_err_s[d]}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid_s[d] = 1'b0;
            req_we_s[d]    = 1'b0;
            req_func3_s[d] = 3'b000;
            req_addr_s[d]  = 32'h0;
            req_wdata_s[d] = 32'h0;
            last_acc[d]    = 0;
            prev_hold[d]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Word store/load
        send(0, 1'b1, F_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        send(0, 1'b0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        // Lanes and extension
        send(0, 1'b1, F_W,  32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0);
        send(0, 1'b1, F_B,  32'h21, 32'h0000009A, 32'h0, 1'b0, 1'b0);
        send(0, 1'b0, F_W,  32'h20, 32'h0, 32'h12349A78, 1'b0, 1'b0);
        send(0, 1'b0, F_B,  32'h21, 32'h0, 32'hFFFFFF9A, 1'b0, 1'b0);
        send(0, 1'b0, F_BU, 32'h21, 32'h0, 32'h0000009A, 1'b0, 1'b0);
        send(0, 1'b0, F_H,  32'h22, 32'h0, 32'h00001234, 1'b0, 1'b0);
        send(0, 1'b1, F_H,  32'h22, 32'h00008001, 32'h0, 1'b0, 1'b0);
        send(0, 1'b0, F_H,  32'h22, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
        send(0, 1'b0, F_HU, 32'h22, 32'h0, 32'h00008001, 1'b0, 1'b0);
        send(0, 1'b0, F_B,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
        send(0, 1'b0, F_BU, 32'h20, 32'h0, 32'h00000078, 1'b0, 1'b0);
        // Errors leave RAM unchanged
        send(0, 1'b0, F_W,    32'h13,  32'h0,        32'h0, 1'b1, 1'b0);
        send(0, 1'b1, F_H,    32'h21,  32'h0000FFFF, 32'h0, 1'b1, 1'b0);
        send(0, 1'b0, 3'b011, 32'h20,  32'h0,        32'h0, 1'b1, 1'b0);
        send(0, 1'b1, 3'b100, 32'h20,  32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        send(0, 1'b0, F_W,    32'h400, 32'h0,        32'h0, 1'b1, 1'b0);
        send(0, 1'b0, F_W,    32'h20,  32'h0, 32'h80019A78, 1'b0, 1'b0);

        // Reset mid-operation aborts the store and clears outputs at once
        send(0, 1'b1, F_W, 32'h40, 32'h11111111, 32'h0, 1'b0, 1'b0);
        send(0, 1'b0, F_W, 32'h40, 32'h0, 32'h11111111, 1'b0, 1'b0);
        req_we_s[0]    = 1'b1;
        req_func3_s[0] = F_W;
        req_addr_s[0]  = 32'h40;
        req_wdata_s[0] = 32'hAAAA5555;
        req_valid_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_s[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        prev_hold[0] = 1'b0;
        @(negedge clk);
        send(0, 1'b0, F_W, 32'h40, 32'h0, 32'h11111111, 1'b0, 1'b0);

        // Back-to-back with valid held high, LATENCY 2
        send(0, 1'b1, F_W,  32'h50, 32'hA5A50001, 32'h0, 1'b0, 1'b1);
        send(0, 1'b0, F_W,  32'h50, 32'h0, 32'hA5A50001, 1'b0, 1'b1);
        send(0, 1'b1, F_H,  32'h52, 32'h000000FF, 32'h0, 1'b0, 1'b1);
        send(0, 1'b0, F_HU, 32'h52, 32'h0, 32'h000000FF, 1'b0, 1'b1);
        send(0, 1'b0, F_W,  32'h50, 32'h0, 32'h00FF0001, 1'b0, 1'b0);

        // Back-to-back, LATENCY 1, 16-word RAM
        send(1, 1'b1, F_W,  32'h3C, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        send(1, 1'b0, F_W,  32'h3C, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        send(1, 1'b0, F_W,  32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
        send(1, 1'b0, F_H,  32'h3E, 32'h0, 32'hFFFFCAFE, 1'b0, 1'b1);
        send(1, 1'b1, F_B,  32'h3D, 32'h00000012, 32'h0, 1'b0, 1'b1);
        send(1, 1'b0, F_BU, 32'h3D, 32'h0, 32'h00000012, 1'b0, 1'b1);
        send(1, 1'b0, F_W,  32'h3C, 32'h0, 32'hCAFE120D, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        check("drain_q0", q0.size(), 32'd0);
        check("drain_q1", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
